// File: rtl/fpe_pkg.sv
// Shared FPE vector datapath constants and index type.
// Defaults here size the vector register file and its decoder-facing scoreboard.
package fpe_pkg;

    localparam int FPE_VEC_W     = 256;
    localparam int FPE_NUM_VREGS = 8;

    typedef logic [$clog2(FPE_NUM_VREGS)-1:0] vreg_idx_t;

endpackage

// File: rtl/vrf_read_port.sv
// One registered read port with write-through bypass; 1-cycle latency.
// No backpressure: a request is always accepted and valid follows it by one edge.
module vrf_read_port
    import fpe_pkg::*;
#(
    parameter int  DATA_W   = FPE_VEC_W,
    parameter int  NUM_REGS = FPE_NUM_VREGS,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic              wr0_vld,
    input  logic [DATA_W-1:0] wr0_dat,
    input  logic              ex_vld,
    input  logic [SEL_W-1:0]  ex_sel,
    input  logic [DATA_W-1:0] ex_dat,
    input  logic              rd,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] rd_dat,
    output logic              rd_vld
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;

    // ex_vld is already qualified against the feature-load conflict, so the
    // two bypass sources never both target register 0 with different data.
    always_comb begin
        data_d = data_q;
        vld_d  = rd;
        if (rd) begin
            if (wr0_vld && (rd_sel == '0)) begin
                data_d = wr0_dat;
            end else if (ex_vld && (ex_sel == rd_sel)) begin
                data_d = ex_dat;
            end else begin
                data_d = regs[rd_sel];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign rd_dat = data_q;
    assign rd_vld = vld_q;

endmodule

// File: rtl/vector_regfile_banked.sv
// Vector register file: two 1-cycle registered read ports, one execute write plus
// priority feature-load into reg 0, and an advisory busy scoreboard; no backpressure.
module vector_regfile_banked
    import fpe_pkg::*;
#(
    parameter int  DATA_W   = FPE_VEC_W,
    parameter int  NUM_REGS = FPE_NUM_VREGS,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_rf,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [DATA_W-1:0]   wrf_data,
    input  logic                wrf0_data_v,
    input  logic [DATA_W-1:0]   wrf0_data,
    input  logic                rd_a,
    input  logic [SEL_W-1:0]    rd_a_sel,
    output logic [DATA_W-1:0]   rrf_a_data,
    output logic                rrf_a_data_v,
    input  logic                rd_b,
    input  logic [SEL_W-1:0]    rd_b_sel,
    output logic [DATA_W-1:0]   rrf_b_data,
    output logic                rrf_b_data_v,
    input  logic                busy_set,
    input  logic [SEL_W-1:0]    busy_set_sel,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wr_conflict
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                conflict_q, conflict_d;
    logic                ex_drop;
    logic                ex_vld;

    assign ex_drop = wr_rf && wrf0_data_v && (wr_sel == '0);
    assign ex_vld  = wr_rf && !ex_drop;

    // Busy clears only where a write actually lands; a same-cycle set wins
    // because it marks a newly issued op.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        conflict_d = ex_drop;
        if (ex_vld) begin
            regs_d[wr_sel] = wrf_data;
            busy_d[wr_sel] = 1'b0;
        end
        if (wrf0_data_v) begin
            regs_d[0] = wrf0_data;
            busy_d[0] = 1'b0;
        end
        if (busy_set) begin
            busy_d[busy_set_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = conflict_q;

    vrf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .regs    (regs_q),
        .wr0_vld (wrf0_data_v),
        .wr0_dat (wrf0_data),
        .ex_vld  (ex_vld),
        .ex_sel  (wr_sel),
        .ex_dat  (wrf_data),
        .rd      (rd_a),
        .rd_sel  (rd_a_sel),
        .rd_dat  (rrf_a_data),
        .rd_vld  (rrf_a_data_v)
    );

    vrf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .regs    (regs_q),
        .wr0_vld (wrf0_data_v),
        .wr0_dat (wrf0_data),
        .ex_vld  (ex_vld),
        .ex_sel  (wr_sel),
        .ex_dat  (wrf_data),
        .rd      (rd_b),
        .rd_sel  (rd_b_sel),
        .rd_dat  (rrf_b_data),
        .rd_vld  (rrf_b_data_v)
    );

endmodule

// File: doc/vector_regfile_banked.md
Name: vector_regfile_banked

Overview:
Parametrised successor to the FPE vector data register file. It holds NUM_REGS vector registers of DATA_W bits and provides two independent read ports, each with a one-cycle registered read and valid. It accepts one write per cycle from the execute path plus a priority feature-load port into register 0. It adds a scoreboard of per-register busy bits, so the FPE decoder can stall on read-after-write hazards while long-latency units are outstanding.

Parameters:
DATA_W, 256, vector register width in bits
NUM_REGS, 8, number of vector registers; power of two, at least 2
SEL_W, $clog2(NUM_REGS), register select width (derived; not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_rf  in  1  execute write enable
wr_sel  in  SEL_W  execute write register index
wrf_data  in  DATA_W  execute write data
wrf0_data_v  in  1  feature-load strobe; writes register 0
wrf0_data  in  DATA_W  feature-load data
rd_a  in  1  read port A request
rd_a_sel  in  SEL_W  read port A index
rrf_a_data  out  DATA_W  read port A data (registered)
rrf_a_data_v  out  1  read port A valid
rd_b  in  1  read port B request
rd_b_sel  in  SEL_W  read port B index
rrf_b_data  out  DATA_W  read port B data (registered)
rrf_b_data_v  out  1  read port B valid
busy_set  in  1  mark register busy (issue of a long-latency op)
busy_set_sel  in  SEL_W  index to mark busy
busy_vec  out  NUM_REGS  per-register busy bits
wr_conflict  out  1  pulse: an execute write was dropped

Behaviour:
- Reset (async, rst_n=0):
  - All registers are 0.
  - rrf_a_data, rrf_b_data, rrf_a_data_v, rrf_b_data_v, busy_vec and wr_conflict are all 0.
- Write priority:
  - If wrf0_data_v is high, register 0 takes wrf0_data.
  - If wr_rf is also high that cycle and wr_sel==0, the execute write is dropped and wr_conflict is 1 the next cycle.
  - If wr_rf is high with wr_sel!=0, it writes normally in the same cycle, in parallel with the feature load.
- Execute write: on a rising edge with wr_rf=1 and no conflict, reg[wr_sel] takes wrf_data.
- Read ports A and B are identical:
  - When rd_x=1, the data register takes reg[rd_x_sel] and rrf_x_data_v goes to 1 at the next edge.
  - When rd_x=0, rrf_x_data_v goes to 0 and rrf_x_data holds its last value.
  - Latency is 1 cycle.
- Write-through bypass: a read that coincides with a write to the same index returns the new data.
  - The feature-load port has priority when its write applies.
  - Both ports may read the same index in the same cycle.
- Scoreboard:
  - busy_vec[i] is set at the edge where busy_set=1 and busy_set_sel==i.
  - busy_vec[i] is cleared at the edge where any write actually lands in reg i: execute write to i, or feature load when i==0.
  - A dropped write does not clear the busy bit.
  - If set and clear hit the same index in the same cycle, set wins (a new op was issued).
  - Busy state has no effect on reads or writes; it is advisory to the decoder.
- wr_conflict is a single-cycle registered pulse.
- Out-of-range indices cannot occur because NUM_REGS is a power of two.
- Reset asserted mid-operation clears everything immediately, including any in-flight valid.

Decomposition:
- fpe_pkg holds:
  - the FPE_VEC_W=256 and FPE_NUM_VREGS=8 constants, used as defaults;
  - a vreg_idx_t typedef sized by $clog2 of FPE_NUM_VREGS.
- One sub-module, vrf_read_port: registered read with bypass compare. It is instantiated twice, for A and B.
- Storage and scoreboard live in the top level.

Test Plan:
- Reset, then read regs 0..7 on both ports -> all data 0; valid goes high 1 cycle after each rd.
- Write reg3=0xA5 repeated (all 256 bits), and read A at reg3 in the same cycle -> rrf_a_data=0xA5 pattern next cycle (bypass); read B reg3 on the following cycle -> same value.
- Same cycle: wrf0_data_v with data 0x11.., and wr_rf with wr_sel=0 and data 0x22.. -> reg0=0x11..; wr_conflict=1 for exactly 1 cycle.
- Same cycle: wrf0_data_v, plus wr_rf with wr_sel=5 -> reg0 and reg5 both updated; wr_conflict=0.
- Set busy for reg2, then wait 3 cycles -> busy_vec=0x04. Then write reg2 -> busy_vec=0x00 next cycle. Then busy_set on reg2 together with a reg2 write -> busy_vec stays 0x04.
- Assert rst_n=0 mid-stream with both valids high -> all outputs 0 immediately, without waiting for a clock edge.
